// File: rtl/fault_pkg.sv
// Shared types and helpers for the fault applier.
//   fa_state_t : injection FSM states
//   bit_mask() : one-hot mask for a bit index, MASK_MAX_W wide; callers
//                size-cast the result down to their own stream width.
package fault_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,  // injection disarmed, stream passes untouched
      ST_ARMED    = 2'd1,  // waiting for a fault request
      ST_PENDING  = 2'd2,  // fault latched, applies to the next accepted beat
      ST_COOLDOWN = 2'd3   // recently injected, new requests are dropped
   } fa_state_t;

   // Widest stream the mask helper supports.
   localparam int unsigned MASK_MAX_W = 256;

   function automatic logic [MASK_MAX_W-1:0] bit_mask(input int unsigned idx);
      bit_mask = MASK_MAX_W'(1) << idx;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc=1, sticks at all-ones.
// Ports:
//   clk   : clock
//   rst   : asynchronous active-high reset, clears the count
//   inc   : increment request for this cycle
//   count : current count
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/fault_applier.sv
// Inline fault applier: flips one bit of one beat of a valid/ready stream
// in response to a fault pulse + bit index, with a cooldown after each
// injection. One register stage, one cycle latency.
//
// Handshake: a beat transfers on a port in any cycle where valid and ready
// are both high; valid, once raised, holds with stable data until it
// transfers. Here in_ready = !out_valid || out_ready.
//
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   enable             : 1 = injection armed, 0 = transparent pass-through
//   fault_i, index_i   : fault request pulse and its bit index
//   in_valid/in_ready/in_data    : upstream stream
//   out_valid/out_ready/out_data : downstream stream
//   out_flipped        : current output beat carries an injected fault
//   inj_count          : faults applied (saturating)
//   drop_count         : fault requests discarded (saturating)
//   state_o            : injection FSM state, for observation
module fault_applier
   import fault_pkg::*;
#(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned IDX_W    = 8,
   parameter int unsigned COOLDOWN = 4,
   parameter int unsigned CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              fault_i,
   input  logic [IDX_W-1:0]  index_i,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_flipped,
   output logic [CNT_W-1:0]  inj_count,
   output logic [CNT_W-1:0]  drop_count,
   output fa_state_t         state_o
);

   localparam int unsigned CD_W = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);

   fa_state_t          state_q, state_d;
   logic [CD_W-1:0]    cnt_q, cnt_d;
   // Latched index, already reduced mod DATA_W.
   logic [IDX_W-1:0]   bit_q, bit_d;
   logic [DATA_W-1:0]  data_q;
   logic               valid_q;
   logic               flipped_q;

   logic               accept;
   logic               apply;
   logic               inj_inc;
   logic               drop_inc;
   logic [DATA_W-1:0]  mask;

   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign mask     = DATA_W'(bit_mask(32'(bit_q)));

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      apply    = 1'b0;
      inj_inc  = 1'b0;
      drop_inc = 1'b0;
      if (!enable) begin
         // Disarming wins over everything; a latched fault is thrown away.
         state_d = ST_IDLE;
         if (state_q == ST_PENDING) drop_inc = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_ARMED;
            ST_ARMED: begin
               // A beat accepted this same cycle is not touched.
               if (fault_i) begin
                  bit_d   = index_i & IDX_W'(DATA_W - 1);
                  state_d = ST_PENDING;
               end
            end
            ST_PENDING: begin
               if (accept) begin
                  apply   = 1'b1;
                  inj_inc = 1'b1;
                  if (COOLDOWN == 0) begin
                     state_d = ST_ARMED;
                  end else begin
                     state_d = ST_COOLDOWN;
                     cnt_d   = CD_W'(COOLDOWN);
                  end
               end
               // Only one fault outstanding: the first one is kept.
               if (fault_i) drop_inc = 1'b1;
            end
            ST_COOLDOWN: begin
               if (fault_i) drop_inc = 1'b1;
               if (cnt_q <= CD_W'(1)) begin
                  state_d = ST_ARMED;
               end else begin
                  cnt_d = cnt_q - CD_W'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         flipped_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         if (accept) begin
            data_q    <= apply ? (in_data ^ mask) : in_data;
            flipped_q <= apply;
            valid_q   <= 1'b1;
         end else if (out_ready) begin
            valid_q   <= 1'b0;
            flipped_q <= 1'b0;
         end
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_inj_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (inj_inc),
      .count (inj_count)
   );

   sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (drop_inc),
      .count (drop_count)
   );

   assign out_valid   = valid_q;
   assign out_data    = data_q;
   assign out_flipped = flipped_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_fault_applier.sv
// Directed bench for fault_applier (DATA_W=32, IDX_W=8, COOLDOWN=4, CNT_W=16)
// plus a narrow sat_counter instance to reach saturation quickly.
module tb_fault_applier;
   import fault_pkg::*;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned IDX_W  = 8;
   localparam int unsigned CNT_W  = 16;

   // clock / reset
   logic clk;
   logic rst;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic              enable;
   logic              fault_i;
   logic [IDX_W-1:0]  index_i;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_flipped;
   logic [CNT_W-1:0]  inj_count;
   logic [CNT_W-1:0]  drop_count;
   fa_state_t         state_o;

   logic              sat_rst;
   logic              sat_inc;
   logic [2:0]        sat_cnt;

   int tests;
   int fails;

   fault_applier #(.DATA_W(DATA_W), .IDX_W(IDX_W), .COOLDOWN(4), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .fault_i     (fault_i),
      .index_i     (index_i),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_flipped (out_flipped),
      .inj_count   (inj_count),
      .drop_count  (drop_count),
      .state_o     (state_o)
   );

   sat_counter #(.CNT_W(3)) u_sat (
      .clk   (clk),
      .rst   (sat_rst),
      .inc   (sat_inc),
      .count (sat_cnt)
   );

   // driver helpers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_armed(input string tag);
      int n;
      n = 0;
      while (state_o != ST_ARMED && n < 10) begin
         tick();
         n++;
      end
      tests++;
      if (state_o !== ST_ARMED) begin
         $display("FAIL %s_armed: state=%0d expected=%0d", tag, state_o, ST_ARMED);
         fails++;
      end
   endtask

   task automatic test_reset();
      #2;
      tests++;
      if (out_valid !== 1'b0) begin $display("FAIL reset_valid: got=%b exp=0", out_valid); fails++; end
      tests++;
      if (out_data !== 32'h0) begin $display("FAIL reset_data: got=%h exp=0", out_data); fails++; end
      tests++;
      if (out_flipped !== 1'b0) begin $display("FAIL reset_flipped: got=%b exp=0", out_flipped); fails++; end
      tests++;
      if (inj_count !== 16'd0 || drop_count !== 16'd0) begin
         $display("FAIL reset_counts: inj=%0d drop=%0d exp=0/0", inj_count, drop_count); fails++;
      end
      tests++;
      if (state_o !== ST_IDLE) begin $display("FAIL reset_state: got=%0d exp=%0d", state_o, ST_IDLE); fails++; end
      @(negedge clk);
      rst = 1'b0;
      sat_rst = 1'b0;
   endtask

   task automatic test_saturation();
      sat_inc = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      tests++;
      if (sat_cnt !== 3'd3) begin $display("FAIL sat_count3: got=%0d exp=3", sat_cnt); fails++; end
      for (int i = 0; i < 7; i++) tick();
      tests++;
      if (sat_cnt !== 3'd7) begin $display("FAIL sat_hold: got=%0d exp=7", sat_cnt); fails++; end
      sat_inc = 1'b0;
   endtask

   task automatic test_disabled();
      enable = 1'b0;
      for (int i = 0; i < 16; i++) begin
         fault_i  = 1'b1;
         index_i  = IDX_W'(i);
         in_valid = 1'b1;
         in_data  = DATA_W'(i);
         tick();
         tests++;
         if (out_valid !== 1'b1 || out_data !== DATA_W'(i) || out_flipped !== 1'b0) begin
            $display("FAIL disabled_beat%0d: valid=%b data=%h flip=%b exp=1/%h/0",
                     i, out_valid, out_data, out_flipped, DATA_W'(i));
            fails++;
         end
      end
      fault_i  = 1'b0;
      in_valid = 1'b0;
      tests++;
      if (inj_count !== 16'd0 || drop_count !== 16'd0) begin
         $display("FAIL disabled_counts: inj=%0d drop=%0d exp=0/0", inj_count, drop_count); fails++;
      end
      tests++;
      if (state_o !== ST_IDLE) begin $display("FAIL disabled_state: got=%0d exp=%0d", state_o, ST_IDLE); fails++; end
   endtask

   task automatic test_basic_inject();
      enable = 1'b1;
      tick();
      tests++;
      if (state_o !== ST_ARMED) begin $display("FAIL basic_arm: state=%0d exp=%0d", state_o, ST_ARMED); fails++; end
      fault_i = 1'b1;
      index_i = 8'h25;
      tick();
      fault_i = 1'b0;
      tests++;
      if (state_o !== ST_PENDING) begin $display("FAIL basic_pending: state=%0d exp=%0d", state_o, ST_PENDING); fails++; end
      in_valid = 1'b1;
      in_data  = 32'h0000_0000;
      tick();
      tests++;
      if (out_data !== 32'h0000_0020 || out_flipped !== 1'b1) begin
         $display("FAIL basic_flip: data=%h flip=%b exp=00000020/1", out_data, out_flipped); fails++;
      end
      tests++;
      if (inj_count !== 16'd1) begin $display("FAIL basic_inj: got=%0d exp=1", inj_count); fails++; end
      in_data = 32'h0000_1234;
      tick();
      in_valid = 1'b0;
      tests++;
      if (out_data !== 32'h0000_1234 || out_flipped !== 1'b0) begin
         $display("FAIL basic_next_clean: data=%h flip=%b exp=00001234/0", out_data, out_flipped); fails++;
      end
      wait_armed("basic");
   endtask

   task automatic test_backpressure();
      fault_i = 1'b1;
      index_i = 8'd3;
      tick();
      fault_i   = 1'b0;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h0;
      tick();
      in_data = 32'h0000_00AA;
      for (int i = 0; i < 5; i++) begin
         tests++;
         if (out_valid !== 1'b1 || out_data !== 32'h8 || out_flipped !== 1'b1 || in_ready !== 1'b0) begin
            $display("FAIL bp_hold%0d: valid=%b data=%h flip=%b in_ready=%b exp=1/00000008/1/0",
                     i, out_valid, out_data, out_flipped, in_ready);
            fails++;
         end
         tick();
      end
      out_ready = 1'b1;
      #1;
      tests++;
      if (in_ready !== 1'b1) begin $display("FAIL bp_release_ready: got=%b exp=1", in_ready); fails++; end
      tick();
      in_valid = 1'b0;
      tests++;
      if (out_data !== 32'h0000_00AA || out_flipped !== 1'b0) begin
         $display("FAIL bp_second_beat: data=%h flip=%b exp=000000aa/0", out_data, out_flipped); fails++;
      end
      tests++;
      if (inj_count !== 16'd2) begin $display("FAIL bp_inj: got=%0d exp=2", inj_count); fails++; end
      wait_armed("bp");
   endtask

   task automatic test_cooldown();
      fault_i = 1'b1;
      index_i = 8'd5;
      tick();
      fault_i  = 1'b0;
      in_valid = 1'b1;
      in_data  = 32'h0;
      tick();
      in_valid = 1'b0;
      fault_i  = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      tests++;
      if (drop_count !== 16'd4 || inj_count !== 16'd3) begin
         $display("FAIL cd_counts: drop=%0d inj=%0d exp=4/3", drop_count, inj_count); fails++;
      end
      tests++;
      if (state_o !== ST_ARMED) begin $display("FAIL cd_rearm: state=%0d exp=%0d", state_o, ST_ARMED); fails++; end
      index_i = 8'd7;
      tick();
      fault_i = 1'b0;
      tests++;
      if (state_o !== ST_PENDING || drop_count !== 16'd4) begin
         $display("FAIL cd_fifth: state=%0d drop=%0d exp=%0d/4", state_o, drop_count, ST_PENDING); fails++;
      end
      in_valid = 1'b1;
      in_data  = 32'h0;
      tick();
      in_valid = 1'b0;
      tests++;
      if (out_data !== 32'h0000_0080 || out_flipped !== 1'b1 || inj_count !== 16'd4) begin
         $display("FAIL cd_apply: data=%h flip=%b inj=%0d exp=00000080/1/4", out_data, out_flipped, inj_count);
         fails++;
      end
      wait_armed("cd");
   endtask

   task automatic test_same_cycle();
      fault_i  = 1'b1;
      index_i  = 8'd31;
      in_valid = 1'b1;
      in_data  = 32'hFFFF_FFFF;
      tick();
      fault_i = 1'b0;
      tests++;
      if (out_data !== 32'hFFFF_FFFF || out_flipped !== 1'b0) begin
         $display("FAIL same_clean: data=%h flip=%b exp=ffffffff/0", out_data, out_flipped); fails++;
      end
      tick();
      in_valid = 1'b0;
      tests++;
      if (out_data !== 32'h7FFF_FFFF || out_flipped !== 1'b1 || inj_count !== 16'd5) begin
         $display("FAIL same_next: data=%h flip=%b inj=%0d exp=7fffffff/1/5", out_data, out_flipped, inj_count);
         fails++;
      end
      wait_armed("same");
   endtask

   task automatic test_disable_and_reset();
      fault_i = 1'b1;
      index_i = 8'd2;
      tick();
      fault_i = 1'b0;
      enable  = 1'b0;
      tick();
      tests++;
      if (state_o !== ST_IDLE || drop_count !== 16'd5) begin
         $display("FAIL dis_pending: state=%0d drop=%0d exp=%0d/5", state_o, drop_count, ST_IDLE); fails++;
      end
      enable = 1'b1;
      tick();
      in_valid = 1'b1;
      in_data  = 32'h0000_003C;
      tick();
      in_valid = 1'b0;
      tests++;
      if (out_data !== 32'h0000_003C || out_flipped !== 1'b0 || inj_count !== 16'd5) begin
         $display("FAIL dis_next_clean: data=%h flip=%b inj=%0d exp=0000003c/0/5", out_data, out_flipped, inj_count);
         fails++;
      end
      tick();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h0000_0055;
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_data !== 32'h0000_0055) begin
         $display("FAIL rst_pre: valid=%b data=%h exp=1/00000055", out_valid, out_data); fails++;
      end
      #1;
      rst = 1'b1;
      #1;
      tests++;
      if (out_valid !== 1'b0 || out_data !== 32'h0) begin
         $display("FAIL rst_async: valid=%b data=%h exp=0/00000000", out_valid, out_data); fails++;
      end
      tests++;
      if (inj_count !== 16'd0 || drop_count !== 16'd0 || state_o !== ST_IDLE) begin
         $display("FAIL rst_counts: inj=%0d drop=%0d state=%0d exp=0/0/%0d", inj_count, drop_count, state_o, ST_IDLE);
         fails++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      tests     = 0;
      fails     = 0;
      rst       = 1'b1;
      sat_rst   = 1'b1;
      sat_inc   = 1'b0;
      enable    = 1'b0;
      fault_i   = 1'b0;
      index_i   = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      test_reset();
      test_saturation();
      test_disabled();
      test_basic_inject();
      test_backpressure();
      test_cooldown();
      test_same_cycle();
      test_disable_and_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded 200000 time units");
      $fatal(1, "timeout");
   end

endmodule
